// File: rtl/clean_cycle_control_pkg.sv
// ============================================================================
// Module : clean_cycle_control_pkg
// Brief  : Shared state encodings, BCD constants and the 2-digit BCD decrement.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clean_cycle_control_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLEANING = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_99 = 8'h99;

  localparam logic [7:0] DEF_REMIND_HOURS = 8'h10;
  localparam logic [7:0] DEF_CLEAN_MIN    = 8'h03;
  localparam logic [7:0] DEF_CLEAN_SEC    = 8'h00;

  // 00 wraps to the field's top value; a zero units digit borrows from tens.
  function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] wrap);
    logic [7:0] r;
    if (v == BCD_00)
      r = wrap;
    else if (v[3:0] == 4'h0)
      r = {v[7:4] - 4'h1, 4'h9};
    else
      r = {v[7:4], v[3:0] - 4'h1};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clean_cycle_control_bcd2_down.sv
// ============================================================================
// Module : bcd2_down
// Brief  : 2-digit BCD down-counter with load, clear, decrement and borrow out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2_down
  import clean_cycle_control_pkg::*;
#(
  parameter logic [7:0] WRAP = BCD_59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec_en,
  output logic [7:0] value,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      value <= BCD_00;
    else if (load)
      value <= load_val;
    else if (dec_en)
      value <= bcd2_dec(value, WRAP);
  end

  assign borrow_out = dec_en & (value == BCD_00);

endmodule

`default_nettype wire

// File: rtl/clean_cycle_control.sv
// ============================================================================
// Module : clean_cycle_control
// Brief  : Self-clean cycle FSM, BCD mm:ss countdown and worktime reminder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clean_cycle_control
  import clean_cycle_control_pkg::*;
#(
  parameter logic [7:0] REMIND_HOURS = DEF_REMIND_HOURS,
  parameter logic [7:0] CLEAN_MIN    = DEF_CLEAN_MIN,
  parameter logic [7:0] CLEAN_SEC    = DEF_CLEAN_SEC
) (
  input  logic        clkout,
  input  logic        rst,
  input  logic        tick_1s,
  input  logic        power_on,
  input  logic [23:0] worktime,
  input  logic        clean_req,
  input  logic        clean_cancel,
  output logic        cleaning,
  output logic [15:0] clean_remain,
  output logic        clean_worktime_yet,
  output logic        clean_reminder
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] ss_val;
  logic [7:0] mm_val;
  logic       ss_borrow;
  logic       mm_borrow;
  logic       ss_dec;
  logic       start;
  logic       abort;
  logic       at_one;
  logic       unused_bits;

  assign start  = (state == ST_IDLE) & power_on & clean_req;
  assign abort  = ~power_on | ((state == ST_CLEANING) & clean_cancel);
  assign ss_dec = (state == ST_CLEANING) & power_on & tick_1s & ~clean_cancel;
  assign at_one = ({mm_val, ss_val} == 16'h0001);

  bcd2_down #(.WRAP(BCD_59)) u_ss (
    .clk        (clkout),
    .rst        (rst),
    .clr        (abort),
    .load       (start),
    .load_val   (CLEAN_SEC),
    .dec_en     (ss_dec),
    .value      (ss_val),
    .borrow_out (ss_borrow)
  );

  bcd2_down #(.WRAP(BCD_99)) u_mm (
    .clk        (clkout),
    .rst        (rst),
    .clr        (abort),
    .load       (start),
    .load_val   (CLEAN_MIN),
    .dec_en     (ss_borrow),
    .value      (mm_val),
    .borrow_out (mm_borrow)
  );

  always_comb begin
    state_nxt = state;
    if (!power_on) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (clean_req) state_nxt = ST_CLEANING;
        ST_CLEANING: begin
          if (clean_cancel)          state_nxt = ST_IDLE;
          else if (tick_1s && at_one) state_nxt = ST_CLEAR;
        end
        ST_CLEAR:    state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reminder is gated by the current cleaning flag, so it drops one cycle after entry.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state          <= ST_IDLE;
      clean_reminder <= 1'b0;
    end else begin
      state          <= state_nxt;
      clean_reminder <= power_on & ~cleaning & (worktime[23:16] >= REMIND_HOURS);
    end
  end

  assign cleaning           = (state == ST_CLEANING);
  assign clean_worktime_yet = (state == ST_CLEAR);
  assign clean_remain       = cleaning ? {mm_val, ss_val} : 16'h0000;

  assign unused_bits = ^worktime[15:0] ^ mm_borrow;

endmodule

`default_nettype wire

// File: tb/tb_clean_cycle_control.sv
// ============================================================================
// Module : tb_clean_cycle_control
// Brief  : Directed literal checks plus randomized run against a seconds-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clean_cycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1s = 1'b0;
  logic        power_on = 1'b1;
  logic [23:0] worktime = 24'h0;
  logic        clean_req = 1'b0;
  logic        clean_cancel = 1'b0;
  logic        cleaning;
  logic [15:0] clean_remain;
  logic        clean_worktime_yet;
  logic        clean_reminder;

  int n_cmp = 0;
  int n_err = 0;

  clean_cycle_control dut (
    .clkout             (clk),
    .rst                (rst),
    .tick_1s            (tick_1s),
    .power_on           (power_on),
    .worktime           (worktime),
    .clean_req          (clean_req),
    .clean_cancel       (clean_cancel),
    .cleaning           (cleaning),
    .clean_remain       (clean_remain),
    .clean_worktime_yet (clean_worktime_yet),
    .clean_reminder     (clean_reminder)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Model: mode 0=idle 1=cleaning 2=clear; remaining time kept as plain seconds.
  int  m_mode = 0;
  int  m_secs = 0;
  bit  m_rem  = 0;
  bit  m_valid = 0;

  always @(posedge clk) begin
    bit was_cleaning;
    int hours;
    was_cleaning = (m_mode == 1);
    hours = int'(worktime[23:20]) * 10 + int'(worktime[19:16]);
    if (rst) begin
      m_mode = 0; m_secs = 0; m_rem = 0;
    end else begin
      m_rem = power_on && !was_cleaning && (hours >= 10);
      if (!power_on) begin
        m_mode = 0; m_secs = 0;
      end else if (m_mode == 0) begin
        if (clean_req) begin m_mode = 1; m_secs = 180; end
      end else if (m_mode == 1) begin
        if (clean_cancel) begin
          m_mode = 0; m_secs = 0;
        end else if (tick_1s) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
    end
    m_valid = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] exp_remain;
    if (m_valid) begin
      exp_remain = (m_mode == 1) ? {to_bcd(m_secs / 60), to_bcd(m_secs % 60)} : 16'h0;
      chk("model_cleaning", 32'(cleaning), 32'(m_mode == 1));
      chk("model_remain", 32'(clean_remain), 32'(exp_remain));
      chk("model_pulse", 32'(clean_worktime_yet), 32'(m_mode == 2));
      chk("model_reminder", 32'(clean_reminder), 32'(m_rem));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clean_req = 0; clean_cancel = 0; tick_1s = 0;
  endtask

  task automatic start_and_tick(input int n);
    clean_req = 1; cyc(); clean_req = 0;
    tick_1s = 1;
    repeat (n) cyc();
    tick_1s = 0;
  endtask

  initial begin
    int pulses;
    // Reset state
    cyc();
    chk("rst_cleaning", 32'(cleaning), 32'h0);
    chk("rst_remain", 32'(clean_remain), 32'h0);
    chk("rst_pulse", 32'(clean_worktime_yet), 32'h0);
    chk("rst_reminder", 32'(clean_reminder), 32'h0);
    rst = 0;

    // Full cycle with borrow points
    clean_req = 1; cyc(); clean_req = 0;
    chk("start_cleaning", 32'(cleaning), 32'h1);
    chk("start_remain", 32'(clean_remain), 32'h0300);
    tick_1s = 1;
    pulses = 0;
    for (int t = 1; t <= 180; t++) begin
      cyc();
      if (clean_worktime_yet) pulses++;
      if (t == 1)   chk("tick1_remain", 32'(clean_remain), 32'h0259);
      if (t == 120) chk("t120_remain", 32'(clean_remain), 32'h0100);
      if (t == 121) chk("borrow_mm_remain", 32'(clean_remain), 32'h0059);
      if (t == 170) chk("t170_remain", 32'(clean_remain), 32'h0010);
      if (t == 171) chk("borrow_ss_remain", 32'(clean_remain), 32'h0009);
    end
    chk("done_cleaning", 32'(cleaning), 32'h0);
    chk("done_remain", 32'(clean_remain), 32'h0);
    tick_1s = 0;
    cyc();
    if (clean_worktime_yet) pulses++;
    chk("pulse_count", 32'(pulses), 32'h1);
    chk("after_clear_pulse", 32'(clean_worktime_yet), 32'h0);

    // Reset mid-cycle
    start_and_tick(90);
    chk("pre_rst_remain", 32'(clean_remain), 32'h0130);
    rst = 1; cyc(); rst = 0;
    chk("midrst_cleaning", 32'(cleaning), 32'h0);
    chk("midrst_remain", 32'(clean_remain), 32'h0);
    chk("midrst_pulse", 32'(clean_worktime_yet), 32'h0);
    cyc();
    chk("midrst_pulse2", 32'(clean_worktime_yet), 32'h0);

    // Cancel beats tick at 00:01
    start_and_tick(179);
    chk("pre_cancel_remain", 32'(clean_remain), 32'h0001);
    clean_cancel = 1; tick_1s = 1; cyc(); idle_inputs();
    chk("cancel_cleaning", 32'(cleaning), 32'h0);
    chk("cancel_remain", 32'(clean_remain), 32'h0);
    chk("cancel_pulse", 32'(clean_worktime_yet), 32'h0);
    cyc();
    chk("cancel_pulse2", 32'(clean_worktime_yet), 32'h0);

    // Power drop at 02:00
    start_and_tick(60);
    chk("pre_off_remain", 32'(clean_remain), 32'h0200);
    power_on = 0; cyc();
    chk("off_cleaning", 32'(cleaning), 32'h0);
    chk("off_remain", 32'(clean_remain), 32'h0);
    chk("off_pulse", 32'(clean_worktime_yet), 32'h0);
    clean_req = 1; cyc(); clean_req = 0;
    chk("off_req_ignored", 32'(cleaning), 32'h0);
    power_on = 1;

    // Reminder threshold
    worktime = 24'h095959; cyc();
    chk("rem_below", 32'(clean_reminder), 32'h0);
    worktime = 24'h100000;
    chk("rem_latency", 32'(clean_reminder), 32'h0);
    cyc();
    chk("rem_rise", 32'(clean_reminder), 32'h1);
    clean_req = 1; cyc(); clean_req = 0;
    cyc();
    chk("rem_cleaning", 32'(clean_reminder), 32'h0);
    clean_cancel = 1; cyc(); clean_cancel = 0;
    cyc();
    chk("rem_back", 32'(clean_reminder), 32'h1);
    worktime = 24'h0; cyc();
    chk("rem_cleared", 32'(clean_reminder), 32'h0);

    // Randomized run against the model
    for (int i = 0; i < 6000; i++) begin
      int hh;
      rst          = ($urandom_range(0, 299) == 0);
      power_on     = ($urandom_range(0, 99) != 0);
      clean_req    = ($urandom_range(0, 39) == 0);
      clean_cancel = ($urandom_range(0, 2999) == 0);
      tick_1s      = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 49) == 0) begin
        hh = $urandom_range(0, 12);
        worktime = {to_bcd(hh), to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59))};
      end
      cyc();
    end
    rst = 0; idle_inputs();
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
